// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - power-up rom-to-ram data image copier that holds top_core in reset until the copy completes; optional readback pass under BOOT_VERIFY_EN
module boot_loader #(
  parameter int                XLEN       = 32,
  parameter int                AWIDTH     = 12,
  parameter logic [AWIDTH-1:0] SRC_BASE   = 'h800,
  parameter logic [AWIDTH-1:0] DST_BASE   = 'h000,
  parameter int                COPY_BYTES = 'h800
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              boot_err,
  input  logic [AWIDTH-1:0] core_inst_addr,
  output logic [AWIDTH-1:0] rom_addr,
  input  logic [XLEN-1:0]   rom_data,
  input  logic [AWIDTH-1:0] core_addr,
  input  logic [XLEN-1:0]   core_wdata,
  input  logic [2:0]        core_we,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [XLEN-1:0]   ram_wdata,
  output logic [2:0]        ram_we,
  input  logic [XLEN-1:0]   ram_rdata
);

`ifdef BOOT_VERIFY_EN
  typedef enum logic [2:0] {S_INIT, S_FETCH, S_STORE, S_VRD, S_VCMP, S_RELEASE, S_RUN} state_t;
`else
  typedef enum logic [2:0] {S_INIT, S_FETCH, S_STORE, S_RELEASE, S_RUN} state_t;
`endif

  // offset of the final word; only meaningful when COPY_BYTES is nonzero
  localparam logic [AWIDTH-1:0] LAST_OFF = AWIDTH'((COPY_BYTES >= 4) ? COPY_BYTES - 4 : 0);
  localparam logic [AWIDTH-1:0] WORD     = AWIDTH'(4);

  state_t            state, state_nxt;
  logic [AWIDTH-1:0] off, off_nxt;

  // state, offset and the registered core-control outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_INIT;
      off        <= '0;
      core_rst_n <= 1'b0;
      busy       <= 1'b1;
      done       <= 1'b0;
    end else begin
      state <= state_nxt;
      off   <= off_nxt;
      if (state == S_RUN) begin
        core_rst_n <= 1'b1;
        busy       <= 1'b0;
        done       <= 1'b1;
      end
    end
  end

  // next state and memory-port steering: copier owns the ports until RUN
  always_comb begin
    state_nxt = state;
    off_nxt   = off;
    rom_addr  = SRC_BASE;
    ram_addr  = DST_BASE;
    ram_wdata = rom_data;
    ram_we    = 3'b000;
    case (state)
      S_INIT: begin
        state_nxt = (COPY_BYTES != 0) ? S_FETCH : S_RELEASE;
      end
      S_FETCH: begin
        rom_addr  = SRC_BASE + off;
        state_nxt = S_STORE;
      end
      S_STORE: begin
        ram_addr = DST_BASE + off;
        ram_we   = 3'b110;
        if (off == LAST_OFF) begin
          off_nxt = '0;
`ifdef BOOT_VERIFY_EN
          state_nxt = S_VRD;
`else
          state_nxt = S_RELEASE;
`endif
        end else begin
          off_nxt   = off + WORD;
          state_nxt = S_FETCH;
        end
      end
`ifdef BOOT_VERIFY_EN
      S_VRD: begin
        rom_addr  = SRC_BASE + off;
        ram_addr  = DST_BASE + off;
        state_nxt = S_VCMP;
      end
      S_VCMP: begin
        rom_addr = SRC_BASE + off;
        ram_addr = DST_BASE + off;
        if (off == LAST_OFF) begin
          off_nxt   = '0;
          state_nxt = S_RELEASE;
        end else begin
          off_nxt   = off + WORD;
          state_nxt = S_VRD;
        end
      end
`endif
      S_RELEASE: begin
        state_nxt = S_RUN;
      end
      S_RUN: begin
        rom_addr  = core_inst_addr;
        ram_addr  = core_addr;
        ram_wdata = core_wdata;
        ram_we    = core_we;
      end
      default: begin
        state_nxt = S_INIT;
      end
    endcase
    if (!rst_n) ram_we = 3'b000;
  end

`ifdef BOOT_VERIFY_EN
  // sticky flag: any readback word differing from its rom source
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      boot_err <= 1'b0;
    end else if (state == S_VCMP && ram_rdata != rom_data) begin
      boot_err <= 1'b1;
    end
  end
`else
  assign boot_err = 1'b0;
  logic unused_rdata;
  assign unused_rdata = ^ram_rdata;
`endif

  // simulation-only sanity checks on the copy size
  always_ff @(posedge clk) begin
    assert (COPY_BYTES % 4 == 0);
    assert (COPY_BYTES <= (1 << AWIDTH));
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - timeline model and directed checks for boot_loader
module tb_boot_loader;

`ifdef BOOT_VERIFY_EN
  localparam bit VERIFY = 1'b1;
  localparam int LAT0   = 2050;
`else
  localparam bit VERIFY = 1'b0;
  localparam int LAT0   = 1026;
`endif
  localparam int N0 = 512;

  logic        clk;
  logic        rst_n;
  int          errors = 0;
  int          checks = 0;
  int          k = 0;
  bit          armed = 0;
  bit          err_model = 0;
  logic        corrupt_req, scramble_req;

  logic        core_rst_n, busy, done, boot_err;
  logic [11:0] core_inst_addr, rom_addr, core_addr, ram_addr;
  logic [31:0] rom_data, core_wdata, ram_wdata, ram_rdata;
  logic [2:0]  core_we, ram_we;

  logic        core_rst_n1, busy1, done1, boot_err1;
  logic [11:0] core_inst_addr1, rom_addr1, core_addr1, ram_addr1;
  logic [31:0] rom_data1, core_wdata1, ram_wdata1, ram_rdata1;
  logic [2:0]  core_we1, ram_we1;

  logic [31:0] rom [1024];
  logic [31:0] ram [1024];

  boot_loader dut (
    .clk(clk), .rst_n(rst_n), .core_rst_n(core_rst_n), .busy(busy), .done(done),
    .boot_err(boot_err), .core_inst_addr(core_inst_addr), .rom_addr(rom_addr),
    .rom_data(rom_data), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_we(core_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  boot_loader #(.COPY_BYTES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .core_rst_n(core_rst_n1), .busy(busy1), .done(done1),
    .boot_err(boot_err1), .core_inst_addr(core_inst_addr1), .rom_addr(rom_addr1),
    .rom_data(rom_data1), .core_addr(core_addr1), .core_wdata(core_wdata1),
    .core_we(core_we1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
    .ram_we(ram_we1), .ram_rdata(ram_rdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // registered-read rom/ram models plus bench-side corruption hooks
  always @(posedge clk) begin
    rom_data  <= rom[rom_addr[11:2]];
    ram_rdata <= ram[ram_addr[11:2]];
    if (ram_we == 3'b110) ram[ram_addr[11:2]] <= ram_wdata;
    if (corrupt_req) ram[5] <= ram[5] ^ 32'h1;
    if (scramble_req) for (int i = 0; i < 1024; i++) ram[i] <= 32'hBAD0_0000 | 32'(i);
  end

  // cycles since the last reset edge
  always @(posedge clk) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // expected outputs from the copy timeline: INIT, N x (FETCH,STORE), [N x (VRD,VCMP)], RELEASE, RUN
  task automatic check_dut(input string tag, input int n,
                           input logic [11:0] ra, input logic [11:0] wa,
                           input logic [31:0] wd, input logic [2:0] we,
                           input logic crst, input logic bsy, input logic dn, input logic berr,
                           input logic [11:0] cia, input logic [11:0] ca,
                           input logic [31:0] cwd, input logic [2:0] cwe);
    int  v, w, j;
    bit  rel;
    logic [2:0] ewe;
    v   = VERIFY ? n : 0;
    rel = (k >= 2*n + 2*v + 3);
    chk({tag, " core_rst_n"}, 32'(crst), 32'(rel));
    chk({tag, " busy"}, 32'(bsy), 32'(!rel));
    chk({tag, " done"}, 32'(dn), 32'(rel));
    chk({tag, " boot_err"}, 32'(berr), 32'(err_model && n > 0 && k >= 2*n + 13));
    ewe = 3'b000;
    if (k == 0 || k == 2*n + 2*v + 1) begin
      chk({tag, " rom_addr idle"}, 32'(ra), 32'h800);
      chk({tag, " ram_addr idle"}, 32'(wa), 32'h000);
    end else if (k <= 2*n) begin
      w = (k - 1) / 2;
      if (k % 2 == 1) begin
        chk({tag, " rom_addr fetch"}, 32'(ra), 32'(12'(32'h800 + 4*w)));
      end else begin
        chk({tag, " ram_addr store"}, 32'(wa), 32'(12'(4*w)));
        chk({tag, " ram_wdata store"}, wd, 32'(w) * 32'h0101_0101);
        ewe = 3'b110;
      end
    end else if (k <= 2*n + 2*v) begin
      j = k - 2*n - 1;
      w = j / 2;
      if (j % 2 == 0) begin
        chk({tag, " ram_addr vrd"}, 32'(wa), 32'(12'(4*w)));
        chk({tag, " rom_addr vrd"}, 32'(ra), 32'(12'(32'h800 + 4*w)));
      end
    end else begin
      chk({tag, " rom_addr run"}, 32'(ra), 32'(cia));
      chk({tag, " ram_addr run"}, 32'(wa), 32'(ca));
      chk({tag, " ram_wdata run"}, wd, cwd);
      ewe = cwe;
    end
    if (!rst_n) ewe = 3'b000;
    chk({tag, " ram_we"}, 32'(we), 32'(ewe));
  endtask

  // per-cycle compare of both instances against the timeline model
  always @(negedge clk) begin
    if (armed) begin
      check_dut("d0", N0, rom_addr, ram_addr, ram_wdata, ram_we, core_rst_n, busy, done,
                boot_err, core_inst_addr, core_addr, core_wdata, core_we);
      check_dut("d1", 0, rom_addr1, ram_addr1, ram_wdata1, ram_we1, core_rst_n1, busy1, done1,
                boot_err1, core_inst_addr1, core_addr1, core_wdata1, core_we1);
    end
  end

  task automatic check_image();
    for (int i = 0; i < N0; i++) chk("ram image", ram[i], 32'(i) * 32'h0101_0101);
  endtask

  // reset, optionally pulse reset again at cycle reset_at, and run until the core is released
  task automatic run_copy(input int reset_at, input bit corrupt, output int lat);
    bit fired;
    fired = 0;
    lat   = -1;
    err_model      = 0;
    core_we        = 3'b110;
    core_addr      = 12'h010;
    core_wdata     = 32'h1234_5678;
    core_inst_addr = 12'h044;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("reset core_rst_n", 32'(core_rst_n), 32'h0);
    chk("reset busy", 32'(busy), 32'h1);
    chk("reset done", 32'(done), 32'h0);
    chk("reset boot_err", 32'(boot_err), 32'h0);
    rst_n = 1'b1;
    for (int c = 0; c < 5000 && lat < 0; c++) begin
      @(posedge clk); #1;
      corrupt_req = 1'b0;
      if (!rst_n) begin
        chk("midcopy reset core_rst_n", 32'(core_rst_n), 32'h0);
        chk("midcopy reset busy", 32'(busy), 32'h1);
        rst_n = 1'b1;
      end else begin
        if (!fired && k == reset_at) begin
          rst_n = 1'b0;
          fired = 1;
        end
        if (k == 2*N0) core_we = 3'b000;
        if (corrupt && k == 2*N0 + 1) begin
          corrupt_req = 1'b1;
          err_model   = 1;
        end
        if (k == 2) chk("zero-copy core_rst_n edge2", 32'(core_rst_n1), 32'h0);
        if (k == 3) chk("zero-copy core_rst_n edge3", 32'(core_rst_n1), 32'h1);
        if (rst_n && core_rst_n) lat = k - 1;
      end
    end
    chk("copy finished", 32'(done), 32'h1);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    corrupt_req = 1'b0;
    scramble_req = 1'b0;
    core_we = 3'b000; core_addr = 12'h0; core_wdata = 32'h0; core_inst_addr = 12'h0;
    core_we1 = 3'b000; core_addr1 = 12'h030; core_wdata1 = 32'h5555_AAAA; core_inst_addr1 = 12'h0A4;
    rom_data1 = 32'h0; ram_rdata1 = 32'h0;
    for (int i = 0; i < 1024; i++)
      rom[i] = (i >= 512) ? 32'(i - 512) * 32'h0101_0101 : (32'hC0DE_0000 | 32'(i));
    @(posedge clk); #1;
    armed = 1;
    @(posedge clk); #1;

    // full copy with core write traffic present
    run_copy(-1, 1'b0, lat);
    chk("latency", 32'(lat), 32'(LAT0));
    check_image();
    chk("ram[3]", ram[3], 32'h0303_0303);
    chk("ram[4] untouched by core", ram[4], 32'h0404_0404);
    chk("ram[100]", ram[100], 32'h6464_6464);
    chk("ram[511]", ram[511], 32'h0101_00FF);

    // passthrough in RUN
    repeat (3) @(posedge clk);
    #1;
    core_addr = 12'h020; core_wdata = 32'hDEAD_BEEF; core_we = 3'b110; core_inst_addr = 12'h124;
    #1;
    chk("run ram_addr", 32'(ram_addr), 32'h020);
    chk("run ram_wdata", ram_wdata, 32'hDEAD_BEEF);
    chk("run ram_we", 32'(ram_we), 32'h6);
    chk("run rom_addr", 32'(rom_addr), 32'h124);
    @(posedge clk); #1;
    core_we = 3'b000;
    chk("core write landed", ram[8], 32'hDEAD_BEEF);

    // scramble ram, reset from RUN, then reset again at word 100
    scramble_req = 1'b1;
    @(posedge clk); #1;
    scramble_req = 1'b0;
    chk("scrambled", ram[0], 32'hBAD0_0000);
    run_copy(201, 1'b0, lat);
    chk("latency after restart", 32'(lat), 32'(LAT0));
    check_image();

`ifdef BOOT_VERIFY_EN
    // corrupt one word ahead of its readback compare
    run_copy(-1, 1'b1, lat);
    chk("verify boot_err", 32'(boot_err), 32'h1);
    chk("verify latency", 32'(lat), 32'(4*N0 + 2));
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
